// File: rtl/iob_gray_ptr_rx_pkg.sv
// Shared Gray-code helpers for the iob pointer blocks.
// Both the Gray counter (encoder) and the pointer receiver (decoder) use these
// functions, so the two sides of a crossing share one definition.
// Callers zero-extend to MAX_W bits and truncate the result back to their
// width. This works because zero upper bits do not change the lower bits of
// the prefix XOR.
package iob_gray_ptr_rx_pkg;

   localparam int unsigned MAX_W = 32;

   // Binary to Gray: g = b ^ (b >> 1)
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/iob_gray_ptr_rx_sync.sv
// Multi-flop synchronizer for a Gray-coded bus.
// Ports: clk_i/arst_n_i clock and async active-low reset; cke_i enable;
//        rst_i sync clear (qualified by cke_i); d_i async input; q_o last stage.
module iob_gray_ptr_rx_sync #(
   parameter int unsigned W      = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk_i,
   input  logic         cke_i,
   input  logic         arst_n_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sync_q [STAGES];
   logic [W-1:0] sync_d [STAGES];

   // Shift chain; a sync clear flushes any value still in flight
   always_comb begin
      sync_d[0] = d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      if (rst_i) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else if (cke_i) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/iob_gray_ptr_rx.sv
// Receiving end of a Gray-coded pointer crossing into the clk_i domain.
// The remote Gray pointer is synchronized, decoded and compared with the local
// binary read pointer to produce level, empty, advance and overflow flags.
// Ports: clk_i, cke_i, arst_n_i (async, active-low), rst_i (sync clear);
//        gray_i remote Gray pointer; rd_ptr_i local binary pointer;
//        bin_o decoded pointer; level_o = bin - rd_ptr (mod 2**W);
//        empty_o level is zero; adv_o/delta_o one-cycle advance pulse and step;
//        overflow_o sticky flag for level above 2**(W-1).
module iob_gray_ptr_rx
   import iob_gray_ptr_rx_pkg::*;
#(
   parameter int unsigned W           = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk_i,
   input  logic         cke_i,
   input  logic         arst_n_i,
   input  logic         rst_i,
   input  logic [W-1:0] gray_i,
   input  logic [W-1:0] rd_ptr_i,
   output logic [W-1:0] bin_o,
   output logic [W-1:0] level_o,
   output logic         empty_o,
   output logic         adv_o,
   output logic [W-1:0] delta_o,
   output logic         overflow_o
);

   localparam int unsigned DEPTH = 1 << (W - 1);

   logic [W-1:0] gray_sync;
   logic [W-1:0] bin_n;
   logic [W-1:0] level_n;

   logic [W-1:0] bin_q,    bin_d;
   logic [W-1:0] level_q,  level_d;
   logic         nempty_q, nempty_d;
   logic         adv_q,    adv_d;
   logic [W-1:0] delta_q,  delta_d;
   logic         ovf_q,    ovf_d;

   iob_gray_ptr_rx_sync #(
      .W      (W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i    (clk_i),
      .cke_i    (cke_i),
      .arst_n_i (arst_n_i),
      .rst_i    (rst_i),
      .d_i      (gray_i),
      .q_o      (gray_sync)
   );

   // Decode and compare; level uses the next bin so it lines up with bin_o
   always_comb begin
      bin_n    = W'(gray2bin(MAX_W'(gray_sync)));
      level_n  = bin_n - rd_ptr_i;

      bin_d    = bin_n;
      level_d  = level_n;
      nempty_d = (level_n != '0);
      adv_d    = (bin_n != bin_q);
      delta_d  = adv_d ? (bin_n - bin_q) : '0;
      ovf_d    = ovf_q | ({1'b0, level_n} > (W+1)'(DEPTH));

      if (rst_i) begin
         bin_d    = '0;
         level_d  = '0;
         nempty_d = 1'b0;
         adv_d    = 1'b0;
         delta_d  = '0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         bin_q    <= '0;
         level_q  <= '0;
         nempty_q <= 1'b0;
         adv_q    <= 1'b0;
         delta_q  <= '0;
         ovf_q    <= 1'b0;
      end else if (cke_i) begin
         bin_q    <= bin_d;
         level_q  <= level_d;
         nempty_q <= nempty_d;
         adv_q    <= adv_d;
         delta_q  <= delta_d;
         ovf_q    <= ovf_d;
      end
   end

   // Empty is kept inverted so every flop clears to zero
   assign bin_o      = bin_q;
   assign level_o    = level_q;
   assign empty_o    = ~nempty_q;
   assign adv_o      = adv_q;
   assign delta_o    = delta_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_iob_gray_ptr_rx.sv
// Self-checking bench for iob_gray_ptr_rx (W=4, SYNC_STAGES=2).
module tb_iob_gray_ptr_rx;

   localparam int W  = 4;
   localparam int SS = 2;
   localparam int MOD = 1 << W;
   localparam int DEPTH = 1 << (W - 1);

   logic         clk = 1'b0;
   logic         cke_i, arst_n_i, rst_i;
   logic [W-1:0] gray_i, rd_ptr_i;
   logic [W-1:0] bin_o, level_o, delta_o;
   logic         empty_o, adv_o, overflow_o;

   iob_gray_ptr_rx #(.W(W), .SYNC_STAGES(SS)) dut (
      .clk_i      (clk),
      .cke_i      (cke_i),
      .arst_n_i   (arst_n_i),
      .rst_i      (rst_i),
      .gray_i     (gray_i),
      .rd_ptr_i   (rd_ptr_i),
      .bin_o      (bin_o),
      .level_o    (level_o),
      .empty_o    (empty_o),
      .adv_o      (adv_o),
      .delta_o    (delta_o),
      .overflow_o (overflow_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: Gray values in flight (per enabled cycle) and expected outputs
   int m_pipe [SS];
   int m_bin, m_level, m_delta;
   bit m_empty, m_adv, m_ovf;

   logic [14:0] dut_vec;
   assign dut_vec = {bin_o, level_o, empty_o, adv_o, delta_o, overflow_o};

   // Decode by searching for the binary value whose Gray code matches
   function automatic int decode(input int g);
      for (int b = 0; b < MOD; b++) begin
         if ((b ^ (b >> 1)) == g) return b;
      end
      return -1;
   endfunction

   function automatic logic [14:0] exp_vec();
      return {4'(m_bin), 4'(m_level), m_empty, m_adv, 4'(m_delta), m_ovf};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < SS; i++) m_pipe[i] = 0;
      m_bin = 0; m_level = 0; m_delta = 0;
      m_empty = 1'b1; m_adv = 1'b0; m_ovf = 1'b0;
   endtask

   // One clock: capture inputs as seen at the edge, advance the model, settle
   task automatic tick();
      int g, r, nb;
      bit c, s, a;
      g = int'(gray_i); r = int'(rd_ptr_i);
      c = cke_i; s = rst_i; a = arst_n_i;
      @(posedge clk);
      #1;
      if (!a) begin
         model_clear();
      end else if (c) begin
         if (s) begin
            model_clear();
         end else begin
            nb      = decode(m_pipe[SS-1]);
            m_adv   = (nb != m_bin);
            m_delta = m_adv ? ((nb - m_bin + MOD) % MOD) : 0;
            m_bin   = nb;
            m_level = (nb - r + MOD) % MOD;
            m_empty = (m_level == 0);
            if (m_level > DEPTH) m_ovf = 1'b1;
            for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = g;
         end
      end
   endtask

   task automatic test_reset();
      cke_i = 1'b1; rst_i = 1'b0; arst_n_i = 1'b0;
      gray_i = 4'b0110; rd_ptr_i = 4'd0;
      model_clear();
      repeat (3) tick();
      n_checks++;
      if (dut_vec !== 15'b0000_0000_1_0_0000_0) $display("FAIL reset_state got %h want %h", dut_vec, 15'b0000_0000_1_0_0000_0);
      else n_pass++;
      arst_n_i = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_checks++;
         if (bin_o !== ((c == 3) ? 4'd4 : 4'd0)) $display("FAIL reset_release c%0d bin got %0d want %0d", c, bin_o, (c == 3) ? 4 : 0);
         else n_pass++;
      end
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_model got %h want %h", dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_steps();
      logic [3:0] seq [3];
      int adv_cnt;
      seq = '{4'b0001, 4'b0011, 4'b0010};
      adv_cnt = 0;
      rd_ptr_i = 4'd0; gray_i = 4'b0000;
      repeat (4) tick();
      for (int k = 0; k < 3; k++) begin
         gray_i = seq[k];
         for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL steps k%0d c%0d got %h want %h", k, c, dut_vec, exp_vec());
            else n_pass++;
            if (adv_o === 1'b1) begin
               adv_cnt++;
               n_checks++;
               if (c != 2 || delta_o !== 4'd1 || level_o !== 4'(k + 1)) $display("FAIL steps_adv k%0d c%0d delta %0d level %0d want c2 delta 1 level %0d", k, c, delta_o, level_o, k + 1);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (adv_cnt != 3 || bin_o !== 4'd3 || empty_o !== 1'b0) $display("FAIL steps_final adv %0d bin %0d empty %0d want 3 3 0", adv_cnt, bin_o, empty_o);
      else n_pass++;
   endtask

   task automatic test_jump();
      bit seen;
      seen = 1'b0;
      gray_i = 4'b0000; rd_ptr_i = 4'd0;
      repeat (4) tick();
      gray_i = 4'b0110;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL jump c%0d got %h want %h", c, dut_vec, exp_vec());
         else n_pass++;
         if (adv_o === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if (delta_o !== 4'd4 || level_o !== 4'd4 || bin_o !== 4'd4) $display("FAIL jump_adv delta %0d level %0d bin %0d want 4 4 4", delta_o, level_o, bin_o);
            else n_pass++;
         end
      end
      n_checks++;
      if (!seen) $display("FAIL jump_pulse got none want one");
      else n_pass++;
   endtask

   task automatic test_wrap();
      bit seen;
      seen = 1'b0;
      gray_i = 4'b1000; rd_ptr_i = 4'd15;
      repeat (4) tick();
      n_checks++;
      if (bin_o !== 4'd15 || empty_o !== 1'b1) $display("FAIL wrap_pre bin %0d empty %0d want 15 1", bin_o, empty_o);
      else n_pass++;
      gray_i = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (adv_o === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if (delta_o !== 4'd1 || level_o !== 4'd1 || bin_o !== 4'd0) $display("FAIL wrap_adv delta %0d level %0d bin %0d want 1 1 0", delta_o, level_o, bin_o);
            else n_pass++;
         end
      end
      n_checks++;
      if (!seen) $display("FAIL wrap_pulse got none want one");
      else n_pass++;
      rd_ptr_i = 4'd0;
      tick();
      n_checks++;
      if (level_o !== 4'd0 || empty_o !== 1'b1) $display("FAIL wrap_rd level %0d empty %0d want 0 1", level_o, empty_o);
      else n_pass++;
   endtask

   task automatic test_overflow();
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      rd_ptr_i = 4'd0; gray_i = 4'b1101;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL ovf c%0d got %h want %h", c, dut_vec, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (level_o !== 4'd9 || overflow_o !== 1'b1) $display("FAIL ovf_set level %0d ovf %0d want 9 1", level_o, overflow_o);
      else n_pass++;
      gray_i = 4'b0000;
      repeat (4) tick();
      n_checks++;
      if (overflow_o !== 1'b1 || level_o !== 4'd0) $display("FAIL ovf_sticky ovf %0d level %0d want 1 0", overflow_o, level_o);
      else n_pass++;
      gray_i = 4'b0110;
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      n_checks++;
      if (dut_vec !== 15'b0000_0000_1_0_0000_0) $display("FAIL ovf_rst got %h want %h", dut_vec, 15'b0000_0000_1_0_0000_0);
      else n_pass++;
      // Re-sync after the clear: empty until the new value arrives
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_checks++;
         if (empty_o !== ((c == 3) ? 1'b0 : 1'b1)) $display("FAIL ovf_resync c%0d empty %0d want %0d", c, empty_o, (c == 3) ? 0 : 1);
         else n_pass++;
      end
   endtask

   task automatic test_cke();
      logic [14:0] frozen;
      gray_i = 4'b0000; rd_ptr_i = 4'd0;
      repeat (4) tick();
      frozen = dut_vec;
      cke_i = 1'b0; gray_i = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL cke_hold c%0d got %h want %h", c, dut_vec, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (bin_o !== 4'd0 || dut_vec !== frozen) $display("FAIL cke_frozen got %h want %h", dut_vec, frozen);
      else n_pass++;
      cke_i = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_checks++;
         if (bin_o !== ((c == 3) ? 4'd1 : 4'd0)) $display("FAIL cke_resume c%0d bin %0d want %0d", c, bin_o, (c == 3) ? 1 : 0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) gray_i = gray_i ^ 4'(1 << $urandom_range(0, W - 1));
         if ($urandom_range(0, 3) == 0) rd_ptr_i = 4'($urandom_range(0, MOD - 1));
         cke_i = ($urandom_range(0, 9) != 0);
         rst_i = ($urandom_range(0, 49) == 0);
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL random n%0d got %h want %h", n, dut_vec, exp_vec());
         else n_pass++;
      end
      cke_i = 1'b1; rst_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_steps();
      test_jump();
      test_wrap();
      test_overflow();
      test_cke();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
